// File: rtl/fetch_pkg.sv
// Shared fetch/branch types: FSM states, instruction size, address and word types.
package fetch_pkg;
  typedef enum logic {S_WAIT, S_HOLD} fetch_state_e;
  localparam int INSTR_BYTES = 4;
  typedef logic [63:0] addr_t;
  typedef logic [31:0] instr_t;
endpackage

// File: rtl/fetch_wait_timer.sv
// Memory-latency timer: counts while enabled, done on the last wait cycle.
module fetch_wait_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);
  logic [3:0] cnt_q;

  assign done_o = (cnt_q == 4'(WAIT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= cnt_q + 4'd1;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, fixed-latency instruction capture, decode handshake, redirects.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          WAIT_CYCLES = 2,
  parameter int          CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic [63:0]       InstrAddr,
  input  logic [31:0]       InstrData,
  output logic [31:0]       Instr,
  output logic [63:0]       InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  input  logic              Redirect,
  input  logic [63:0]       RedirectPC,
  output logic [CNT_W-1:0]  FetchCount
);
  fetch_state_e     state_q, state_d;
  addr_t            pc_q, pc_d, ipc_q, ipc_d;
  instr_t           instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs, wait_done, capture;

  assign hs      = valid_q & InstrReady;
  assign capture = (state_q == S_WAIT) & wait_done;

  // Timer restarts whenever the address changes or the capture completes.
  fetch_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk_i  (CLK),
    .rst_i  (Reset),
    .clr_i  (Redirect | hs | capture),
    .en_i   (state_q == S_WAIT),
    .done_o (wait_done)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: if (wait_done) begin
        instr_d = InstrData;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (hs) begin
        pc_d    = pc_q + addr_t'(INSTR_BYTES);
        valid_d = 1'b0;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
    if (hs) cnt_d = cnt_q + CNT_W'(1);
    // Handshake still counts, but the redirect owns the PC and kills any capture.
    if (Redirect) begin
      pc_d    = {RedirectPC[63:2], 2'b00};
      ipc_d   = ipc_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_WAIT;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstrAddr  = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = ipc_q;
  assign InstrValid = valid_q;
  assign FetchCount = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit against a cycle-count model.
module tb_instr_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        Reset, InstrReady, Redirect, InstrValid;
  logic [63:0] InstrAddr, InstrPC, RedirectPC;
  logic [31:0] InstrData, Instr, FetchCount;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;

  // Model state: PC, cycles since last restart, handshake count.
  logic [63:0] m_pc = RST_PC;
  int          m_age = 0;
  logic [31:0] m_cnt = 0;
  logic        m_valid = 1'b0, m_rst = 1'b1;

  function automatic logic [31:0] memf(input logic [63:0] a);
    case (a)
      64'h00: return 32'hF84003E9;
      64'h04: return 32'hF84083EA;
      64'h08: return 32'hAA0A0128;
      64'h0C: return 32'h8A0A0129;
      64'h10: return 32'hB4000049;
      64'h3C: return 32'hB2048FE9;
      default: return a[31:0] ^ a[63:32] ^ 32'h9E3779B9 ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  assign InstrData = memf(InstrAddr);

  instr_fetch_unit #(.RESET_PC(RST_PC), .WAIT_CYCLES(W), .CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .InstrAddr(InstrAddr), .InstrData(InstrData),
    .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .FetchCount(FetchCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check state against the model, drive inputs, advance the model.
  task automatic step(input logic rdy, input logic rd, input logic [63:0] tgt, input logic rst);
    logic hs;
    @(negedge CLK);
    chk("addr", InstrAddr, m_pc);
    chk("valid", {63'b0, InstrValid}, {63'b0, m_valid});
    chk("count", {32'b0, FetchCount}, {32'b0, m_cnt});
    if (m_valid) begin
      chk("hold_pc", InstrPC, m_pc);
      chk("hold_instr", {32'b0, Instr}, {32'b0, memf(m_pc)});
    end
    if (m_rst) begin
      chk("rst_instr", {32'b0, Instr}, 64'h0);
      chk("rst_ipc", InstrPC, 64'h0);
    end
    Reset = rst; InstrReady = rdy; Redirect = rd; RedirectPC = tgt;
    m_rst = rst;
    if (rst) begin
      m_pc = RST_PC; m_age = 0; m_cnt = 0; sb.delete();
    end else begin
      hs = m_valid && rdy;
      if (hs) begin
        sb.push_back('{pc: m_pc, ins: memf(m_pc), cnt: m_cnt});
        m_cnt++;
      end
      if (rd) begin
        m_pc = {tgt[63:2], 2'b00}; m_age = 0;
      end else if (hs) begin
        m_pc = m_pc + 64'd4; m_age = 0;
      end else if (m_age < W) m_age++;
    end
    m_valid = (m_age == W);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !m_valid; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  // Monitor: every DUT handshake retires the oldest expected fetch.
  always begin
    exp_t e;
    @(negedge CLK);
    #2;
    if (InstrValid === 1'b1 && InstrReady === 1'b1 && Reset === 1'b0) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: handshake pc %h with no expected fetch", InstrPC);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", InstrPC, e.pc);
        chk("sb_instr", {32'b0, Instr}, {32'b0, e.ins});
        chk("sb_count", {32'b0, FetchCount}, {32'b0, e.cnt});
      end
    end
  end

  initial begin
    Reset = 1'b1; InstrReady = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    repeat (2) @(posedge CLK);
    // Program start with Ready high.
    repeat (7) step(1'b1, 1'b0, 64'h0, 1'b0);
    // Backpressure for 5 cycles, then one handshake.
    wait_valid();
    repeat (5) step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    // Redirect during WAIT, unaligned target.
    step(1'b0, 1'b1, 64'h3E, 1'b0);
    wait_valid();
    step(1'b1, 1'b0, 64'h0, 1'b0);
    // Redirect coinciding with a handshake.
    step(1'b0, 1'b1, 64'h28, 1'b0);
    wait_valid();
    step(1'b1, 1'b1, 64'h1C, 1'b0);
    wait_valid();
    step(1'b1, 1'b0, 64'h0, 1'b0);
    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    wait_valid();
    step(1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    // Reset while holding, with a simultaneous redirect.
    wait_valid();
    step(1'b0, 1'b1, 64'h100, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) t = {56'h0, t[7:0]};
      step(($urandom % 4) != 0, ($urandom % 10) == 0, t, ($urandom % 150) == 0);
    end
    repeat (2) step(1'b0, 1'b0, 64'h0, 1'b0);
    #3;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the read-only instruction memory. Holds the 64-bit program counter and drives the memory address. Waits a fixed number of cycles for the memory's read delay, then captures the 32-bit instruction word and hands it to decode over a valid/ready handshake. Accepts branch redirects (B, CBZ taken) from execute and discards any in-flight fetch.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
WAIT_CYCLES, 2, cycles from address change to data capture (covers 20 ns read delay at a 10 ns clock); legal range 1..15.
CNT_W, 32, width of the retired-fetch counter.

Ports:
CLK  in  1  clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
InstrAddr  out  64  address to instruction memory; always equals the internal PC.
InstrData  in  32  instruction word returned by memory.
Instr  out  32  captured instruction, stable while InstrValid=1.
InstrPC  out  64  PC of Instr.
InstrValid  out  1  Instr/InstrPC hold a valid instruction.
InstrReady  in  1  decode accepts when InstrValid&&InstrReady at a clock edge.
Redirect  in  1  one-cycle branch-taken request.
RedirectPC  in  64  branch target; bits [1:0] forced to 0 internally.
FetchCount  out  CNT_W  number of completed handshakes since reset.

Behaviour:
- Reset (sync, high): PC=RESET_PC, state=WAIT, wait counter=0, Instr=32'h0, InstrPC=64'h0, InstrValid=0, FetchCount=0. Reset asserted mid-wait or mid-hold abandons everything; Reset overrides Redirect.
- Single outstanding fetch. FSM states:
  - WAIT: counter increments each cycle. When counter==WAIT_CYCLES-1: capture Instr<=InstrData and InstrPC<=PC, set InstrValid=1, go to HOLD. Capture occurs even if InstrData is X; no checking is done.
  - HOLD: Instr/InstrPC/InstrValid are stable. On handshake: PC<=PC+4, InstrValid<=0, counter<=0, FetchCount+=1, go to WAIT.
- Latency: after reset or a handshake, InstrValid rises WAIT_CYCLES cycles later. Steady-state throughput with InstrReady tied high is one instruction per WAIT_CYCLES+1 cycles.
- Redirect has priority over all PC updates. In any state: PC<={RedirectPC[63:2],2'b00}, counter<=0, InstrValid<=0, state<=WAIT.
  - Redirect in the same cycle as a handshake: the handshake counts (FetchCount increments; decode owns that instruction), and PC takes the redirect target, not PC+4.
  - Redirect during WAIT discards the pending capture.
  - Back-to-back redirects: the last one wins; each restarts the counter.
- Arithmetic: PC+4 is 64-bit modular; 64'hFFFF_FFFF_FFFF_FFFC wraps to 64'h0. FetchCount wraps at 2^CNT_W.
- InstrAddr is a registered output equal to PC; no combinational path from any input to any output.

Decomposition:
- Shared package fetch_pkg: state enum (WAIT, HOLD), constant INSTR_BYTES=4, 64-bit address and 32-bit instruction typedefs. The branch-target computation in execute reuses these.
- Sub-module fetch_wait_timer: counter with clear/enable and a done flag. Parameterized by WAIT_CYCLES; reused later by the data-memory access stage.
- PC register, FSM and handshake logic stay in the top module.

Test Plan:
- Reset with RESET_PC=0, WAIT_CYCLES=2, InstrReady=1, memory model loaded with the load/ORR/AND/CBZ loop program → InstrValid on cycle 2; Instr=32'hF84003E9, InstrPC=0; next capture has InstrPC=4, Instr=32'hF84083EA; FetchCount=2 after the second handshake.
- Backpressure: hold InstrReady=0 for 5 cycles after InstrValid → Instr/InstrPC/InstrAddr unchanged, FetchCount unchanged. Raise Ready → one handshake, then PC=4.
- Redirect with RedirectPC=64'h3E during WAIT → no capture at the old PC; InstrAddr=64'h3C; next Instr=32'hB2048FE9 with InstrPC=64'h3C.
- Redirect to 64'h1C in the same cycle as the handshake of the instruction at 64'h28 → FetchCount increments, next InstrPC=64'h1C (not 64'h2C).
- Redirect to 64'hFFFF_FFFF_FFFF_FFFC, then a handshake → InstrAddr wraps to 64'h0.
- Reset asserted while in HOLD with InstrValid=1 → next cycle InstrValid=0, Instr=0, FetchCount=0, InstrAddr=RESET_PC; Redirect asserted together with Reset is ignored.
